// File: rtl/updown_counter.sv
`default_nettype none
// ============================================================================
//  Module   : updown_counter
//  Purpose  : Parametrised up/down counter with synchronous clear/load,
//             wrap or saturate at the bounds, a one-cycle terminal-count
//             pulse and an optional complemented shadow register that flags
//             glitch-induced corruption of the count.
//  Option   : COUNTER_SHADOW_EN - when defined, builds the shadow register
//             and the sticky fault flag; otherwise fault is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module updown_counter #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned MAX_VALUE   = 32'((64'd1 << WIDTH) - 64'd1),
  parameter bit          SATURATE    = 1'b0,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             up_down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             fault
);

  // Bounds reduced to the counter width once, so every compare is WIDTH bits.
  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] ZERO_V  = '0;

  logic [WIDTH-1:0] next_count;
  logic             next_tc;
  logic             at_top;
  logic             at_bottom;

  // A count above MAX_VALUE can only come from corruption; an up-step then
  // behaves exactly as it would at MAX_VALUE, so ">=" rather than "==".
  assign at_top    = (count >= MAX_V);
  assign at_bottom = (count == ZERO_V);

  // Next-state selection: clear > load > enable > hold.
  always_comb begin
    next_count = count;
    next_tc    = 1'b0;
    if (clear) begin
      next_count = RESET_V;
    end else if (load) begin
      next_count = (load_value > MAX_V) ? MAX_V : load_value;
    end else if (enable) begin
      if (up_down) begin
        if (at_top) begin
          next_count = SATURATE ? MAX_V : ZERO_V;
          next_tc    = 1'b1;
        end else begin
          next_count = count + 1'b1;
        end
      end else begin
        if (at_bottom) begin
          next_count = SATURATE ? ZERO_V : MAX_V;
          next_tc    = 1'b1;
        end else begin
          next_count = count - 1'b1;
        end
      end
    end
  end

  // Primary count and terminal-count pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= RESET_V;
      tc    <= 1'b0;
    end else begin
      count <= next_count;
      tc    <= next_tc;
    end
  end

`ifdef COUNTER_SHADOW_EN
  logic [WIDTH-1:0] shadow;

  // Shadow holds the complement of the count, written from the same
  // next-state value; any disagreement latches fault until reset_n.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow <= ~RESET_V;
      fault  <= 1'b0;
    end else begin
      shadow <= ~next_count;
      if (count != ~shadow) begin
        fault <= 1'b1;
      end
    end
  end
`else
  assign fault = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_updown_counter
//  Purpose  : Randomised plus directed bench for updown_counter. Three
//             instances share stimulus: 8-bit defaults, MAX_VALUE=9 wrap
//             (RESET_VALUE=2) and MAX_VALUE=9 saturate. Each instance has its
//             own integer reference model built from the counting rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_updown_counter;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       up_down;
  logic       clear;
  logic       load;
  logic [7:0] load_value;

  logic [7:0] cnt [N];
  logic       tcs [N];
  logic       flt [N];

  // Reference model state, plain integers.
  int maxv  [N] = '{255, 9, 9};
  int satv  [N] = '{0, 0, 1};
  int rstv  [N] = '{0, 2, 0};
  int mcnt  [N];
  int mtc   [N];
  int mflt  [N];

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  updown_counter u_def (
    .clk(clk), .reset_n(reset_n), .enable(enable), .up_down(up_down),
    .clear(clear), .load(load), .load_value(load_value),
    .count(cnt[0]), .tc(tcs[0]), .fault(flt[0])
  );

  updown_counter #(.WIDTH(8), .MAX_VALUE(9), .SATURATE(1'b0), .RESET_VALUE(2)) u_wrap (
    .clk(clk), .reset_n(reset_n), .enable(enable), .up_down(up_down),
    .clear(clear), .load(load), .load_value(load_value),
    .count(cnt[1]), .tc(tcs[1]), .fault(flt[1])
  );

  updown_counter #(.WIDTH(8), .MAX_VALUE(9), .SATURATE(1'b1), .RESET_VALUE(0)) u_sat (
    .clk(clk), .reset_n(reset_n), .enable(enable), .up_down(up_down),
    .clear(clear), .load(load), .load_value(load_value),
    .count(cnt[2]), .tc(tcs[2]), .fault(flt[2])
  );

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mcnt[i] = rstv[i];
      mtc[i]  = 0;
      mflt[i] = 0;
    end
  endtask

  // Behaviour of one rising edge, from the counting rules.
  task automatic model_edge();
    if (!reset_n) return;
    for (int i = 0; i < N; i++) begin
      int nxt;
      mtc[i] = 0;
      if (clear) begin
        mcnt[i] = rstv[i];
      end else if (load) begin
        mcnt[i] = (int'(load_value) > maxv[i]) ? maxv[i] : int'(load_value);
      end else if (enable && up_down) begin
        nxt = mcnt[i] + 1;
        if (nxt > maxv[i]) begin
          mcnt[i] = (satv[i] != 0) ? maxv[i] : 0;
          mtc[i]  = 1;
        end else begin
          mcnt[i] = nxt;
        end
      end else if (enable) begin
        nxt = mcnt[i] - 1;
        if (nxt < 0) begin
          mcnt[i] = (satv[i] != 0) ? 0 : maxv[i];
          mtc[i]  = 1;
        end else begin
          mcnt[i] = nxt;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s_count%0d", tag, i), int'(cnt[i]), mcnt[i]);
      check($sformatf("%s_tc%0d", tag, i), int'(tcs[i]), mtc[i]);
      check($sformatf("%s_fault%0d", tag, i), int'(flt[i]), mflt[i]);
    end
  endtask

  // One clock: model follows the edge, outputs sampled 1 ns later.
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic set_in(input logic e, input logic ud, input logic c,
                        input logic l, input logic [7:0] lv);
    enable = e; up_down = ud; clear = c; load = l; load_value = lv;
  endtask

  initial begin
    reset_n = 1'b0;
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    model_reset();
    tick("rst");
    tick("rst");
    reset_n = 1'b1;

    // Basic up count on the default instance.
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    for (int k = 0; k < 8; k++) tick("up8");
    check("def_after_8", int'(cnt[0]), 8);
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    for (int k = 0; k < 3; k++) tick("hold");
    check("def_hold", int'(cnt[0]), 8);

    // Asynchronous reset mid-count.
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    tick("pre_rst");
    #3 reset_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    check("def_async_rst", int'(cnt[0]), 0);
    tick("in_rst");
    reset_n = 1'b1;
    tick("post_rst");

    // Wrap / saturate at the top.
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 8'd9);
    tick("load9");
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    tick("top");
    check("wrap_top", int'(cnt[1]), 0);
    check("wrap_top_tc", int'(tcs[1]), 1);
    check("sat_top", int'(cnt[2]), 9);
    for (int k = 0; k < 3; k++) begin
      tick("sat_hold");
      check("sat_hold_tc", int'(tcs[2]), 1);
    end

    // Wrap / saturate at the bottom.
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    tick("load0");
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    tick("bottom");
    check("wrap_bottom", int'(cnt[1]), 9);
    check("sat_bottom", int'(cnt[2]), 0);
    tick("down");

    // Priority and clamp.
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 8'd5);
    tick("clr_prio");
    check("wrap_clr_prio", int'(cnt[1]), 2);
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 8'd5);
    tick("load_prio");
    check("sat_load_prio", int'(cnt[2]), 5);
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 8'd200);
    tick("clamp");
    check("wrap_clamp", int'(cnt[1]), 9);
    check("def_load200", int'(cnt[0]), 200);

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      set_in(($urandom_range(3) != 0), ($urandom_range(1) != 0),
             ($urandom_range(15) == 0), ($urandom_range(11) == 0),
             8'($urandom_range(255)));
      tick("rand");
    end

`ifdef COUNTER_SHADOW_EN
    // Corrupt one bit of the count for a cycle; fault must latch.
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 8'h10);
    tick("pre_force");
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    force u_def.count = 8'h11;
    @(posedge clk);
    #1;
    release u_def.count;
    check("fault_set", int'(flt[0]), 1);
    check("fault_other_wrap", int'(flt[1]), 0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check("fault_sticky", int'(flt[0]), 1);
    end
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all("fault_rst");
    reset_n = 1'b1;
    tick("post_fault");
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Hard stop so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
